// File: rtl/stream_adder_tree_if.sv
// Stream bundle for stream_adder_tree: N joined input channels and one sum output.
// The slave side is the adder; the master side is whatever feeds and drains it.
interface stream_adder_tree_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int OUT_WIDTH    = 16
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i_tdata;
    logic [NUM_CHANNELS-1:0]            data_i_tvalid;
    logic [NUM_CHANNELS-1:0]            data_i_tready;
    logic [OUT_WIDTH-1:0]               data_o_tdata;
    logic                               data_o_tvalid;
    logic                               data_o_tready;
    logic                               overflow_o;

    modport master (
        output data_i_tdata, data_i_tvalid, data_o_tready,
        input  data_i_tready, data_o_tdata, data_o_tvalid, overflow_o
    );

    modport slave (
        input  data_i_tdata, data_i_tvalid, data_o_tready,
        output data_i_tready, data_o_tdata, data_o_tvalid, overflow_o
    );
endinterface

// File: rtl/stream_adder_tree.sv
// Joined N-channel signed adder with a pipelined binary tree and valid/ready flow control.
// Define STREAM_ADDER_TREE_SATURATE_EN to clamp the narrowed output and flag overflow; default wraps.
module stream_adder_tree #(
    parameter int                      NUM_CHANNELS = 4,
    parameter int                      DATA_WIDTH   = 16,
    parameter int                      OUT_WIDTH    = 16,
    parameter logic [NUM_CHANNELS-1:0] CH_SUB_MASK  = '0
) (
    input logic                clk,
    input logic                reset,
    stream_adder_tree_if.slave bus
);
    localparam int CLOG_N    = $clog2(NUM_CHANNELS);
    localparam int SUM_WIDTH = DATA_WIDTH + CLOG_N;
    localparam int L         = (CLOG_N < 1) ? 1 : CLOG_N;

    // Arrays are twice the channel count so every node has a partner; slots past
    // a level's live count stay zero, which turns an unpaired add into a pass-through.
    logic signed [SUM_WIDTH-1:0] operand [2*NUM_CHANNELS];
    logic signed [SUM_WIDTH-1:0] tree    [1:L][2*NUM_CHANNELS];
    logic        [L:1]           vld;
    logic signed [SUM_WIDTH-1:0] final_sum;
    logic [NUM_CHANNELS-1:0]     ready_raw;
    logic                        all_valid;
    logic                        ce;

    always_comb begin
        for (int k = 0; k < 2*NUM_CHANNELS; k++) begin
            operand[k] = '0;
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            operand[k] = SUM_WIDTH'($signed(bus.data_i_tdata[k*DATA_WIDTH +: DATA_WIDTH]));
            if (CH_SUB_MASK[k]) begin
                operand[k] = -operand[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            ready_raw[k] = &(bus.data_i_tvalid | (NUM_CHANNELS'(1) << k));
        end
    end

    assign all_valid         = &bus.data_i_tvalid;
    assign ce                = ~vld[L] | bus.data_o_tready;
    assign bus.data_i_tready = (reset || !ce) ? '0 : ready_raw;
    assign bus.data_o_tvalid = vld[L];
    assign final_sum         = tree[L][0];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int l = 1; l <= L; l++) begin
                for (int i = 0; i < 2*NUM_CHANNELS; i++) begin
                    tree[l][i] <= '0;
                end
            end
        end else if (ce) begin
            vld[1] <= all_valid;
            for (int l = 2; l <= L; l++) begin
                vld[l] <= vld[l-1];
            end
            for (int i = 0; i < 2*NUM_CHANNELS; i++) begin
                if (i < NUM_CHANNELS) begin
                    tree[1][i] <= operand[2*i] + operand[2*i+1];
                end else begin
                    tree[1][i] <= '0;
                end
            end
            for (int l = 2; l <= L; l++) begin
                for (int i = 0; i < 2*NUM_CHANNELS; i++) begin
                    if (i < NUM_CHANNELS) begin
                        tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
                    end else begin
                        tree[l][i] <= '0;
                    end
                end
            end
        end
    end

    generate
        if (OUT_WIDTH < SUM_WIDTH) begin : g_reduce
`ifdef STREAM_ADDER_TREE_SATURATE_EN
            localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
                {{(SUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
                {{(SUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

            always_comb begin
                bus.data_o_tdata = final_sum[OUT_WIDTH-1:0];
                bus.overflow_o   = 1'b0;
                if (final_sum > SAT_MAX) begin
                    bus.data_o_tdata = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                    bus.overflow_o   = 1'b1;
                end else if (final_sum < SAT_MIN) begin
                    bus.data_o_tdata = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                    bus.overflow_o   = 1'b1;
                end
            end
`else
            logic unused_hi;
            assign unused_hi        = ^final_sum[SUM_WIDTH-1:OUT_WIDTH];
            assign bus.data_o_tdata = final_sum[OUT_WIDTH-1:0];
            assign bus.overflow_o   = 1'b0;
`endif
        end else begin : g_full
            assign bus.data_o_tdata = final_sum;
            assign bus.overflow_o   = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_stream_adder_tree.sv
// Directed bench for stream_adder_tree: three instances share one stimulus,
// differing only in subtract mask (none, ch1, ch0).
module tb_stream_adder_tree;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*DW-1:0] tdata;
    logic [N-1:0]  tvalid;
    logic          out_ready;
    int            pass_cnt = 0;
    int            total    = 0;

    always #5 clk = ~clk;

    stream_adder_tree_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus_a ();
    stream_adder_tree_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus_s ();
    stream_adder_tree_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus_n ();

    assign bus_a.data_i_tdata  = tdata;
    assign bus_a.data_i_tvalid = tvalid;
    assign bus_a.data_o_tready = out_ready;
    assign bus_s.data_i_tdata  = tdata;
    assign bus_s.data_i_tvalid = tvalid;
    assign bus_s.data_o_tready = out_ready;
    assign bus_n.data_i_tdata  = tdata;
    assign bus_n.data_i_tvalid = tvalid;
    assign bus_n.data_o_tready = out_ready;

    stream_adder_tree #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CH_SUB_MASK(4'b0000))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    stream_adder_tree #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CH_SUB_MASK(4'b0010))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    stream_adder_tree #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CH_SUB_MASK(4'b0001))
        dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [N*DW-1:0] d, output logic got,
                            output logic [OW-1:0] da, output logic [OW-1:0] ds,
                            output logic [OW-1:0] dn, output logic oa,
                            output logic os, output logic on_);
        tdata = d; tvalid = '1; out_ready = 1'b1;
        tick();
        tvalid = '0;
        got = 1'b0; da = '0; ds = '0; dn = '0; oa = 1'b0; os = 1'b0; on_ = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (bus_a.data_o_tvalid) begin
                got = 1'b1;
                da = bus_a.data_o_tdata; oa = bus_a.overflow_o;
                ds = bus_s.data_o_tdata; os = bus_s.overflow_o;
                dn = bus_n.data_o_tdata; on_ = bus_n.overflow_o;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tvalid = '1; tdata = {4{16'd5}}; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus_a.data_i_tready !== 4'b0000) $display("FAIL reset_tready got %b want 0000", bus_a.data_i_tready);
            else pass_cnt++;
            total++;
            if (bus_a.data_o_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", bus_a.data_o_tvalid);
            else pass_cnt++;
            total++;
            if (bus_a.data_o_tdata !== 16'h0000) $display("FAIL reset_tdata got %h want 0000", bus_a.data_o_tdata);
            else pass_cnt++;
        end
        // two beats enter while the output is stalled, then reset discards both
        reset = 1'b0; out_ready = 1'b0; tdata = {16'd1, 16'd1, 16'd1, 16'd1};
        tick();
        tick();
        total++;
        if (bus_a.data_o_tvalid !== 1'b1) $display("FAIL inflight_tvalid got %b want 1", bus_a.data_o_tvalid);
        else pass_cnt++;
        reset = 1'b1; tvalid = '0;
        tick();
        total++;
        if (bus_a.data_o_tdata !== 16'h0000) $display("FAIL midreset_tdata got %h want 0000", bus_a.data_o_tdata);
        else pass_cnt++;
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_a.data_o_tvalid !== 1'b0) $display("FAIL midreset_flush cycle %0d got %b want 0", i, bus_a.data_o_tvalid);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_basic();
        tdata = {16'd7, 16'hFFCE, 16'd200, 16'd100}; tvalid = '1; out_ready = 1'b1;
        tick();
        tvalid = '0;
        total++;
        if (bus_a.data_o_tvalid !== 1'b0) $display("FAIL basic_early got %b want 0", bus_a.data_o_tvalid);
        else pass_cnt++;
        tick();
        total++;
        if (bus_a.data_o_tvalid !== 1'b1) $display("FAIL basic_tvalid got %b want 1", bus_a.data_o_tvalid);
        else pass_cnt++;
        total++;
        if (bus_a.data_o_tdata !== 16'd257) $display("FAIL basic_sum got %0d want 257", $signed(bus_a.data_o_tdata));
        else pass_cnt++;
        total++;
        if (bus_a.overflow_o !== 1'b0) $display("FAIL basic_ovf got %b want 0", bus_a.overflow_o);
        else pass_cnt++;
        tick();
        total++;
        if (bus_a.data_o_tvalid !== 1'b0) $display("FAIL basic_single_beat got %b want 0", bus_a.data_o_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_join();
        int beats;
        tdata = {16'd4, 16'd3, 16'd2, 16'd1}; tvalid = 4'b1011; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            // ch2's own ready may be high; the valid channels must wait for it
            total++;
            if (bus_a.data_i_tready !== 4'b0100) $display("FAIL join_wait_tready got %b want 0100", bus_a.data_i_tready);
            else pass_cnt++;
            total++;
            if (bus_a.data_o_tvalid !== 1'b0) $display("FAIL join_wait_tvalid got %b want 0", bus_a.data_o_tvalid);
            else pass_cnt++;
            tick();
        end
        tvalid = 4'b1111;
        #1;
        total++;
        if (bus_a.data_i_tready !== 4'b1111) $display("FAIL join_all_ready got %b want 1111", bus_a.data_i_tready);
        else pass_cnt++;
        tick();
        tvalid = '0;
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_a.data_o_tvalid) begin
                beats++;
                total++;
                if (bus_a.data_o_tdata !== 16'd10) $display("FAIL join_sum got %0d want 10", $signed(bus_a.data_o_tdata));
                else pass_cnt++;
            end
        end
        total++;
        if (beats !== 1) $display("FAIL join_beats got %0d want 1", beats);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int idx, rcv;
        logic in_fire, out_fire;
        idx = 0; rcv = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (idx < 8) begin
                tdata = {16'(idx + 3), 16'(idx + 2), 16'(idx + 1), 16'(idx)};
                tvalid = '1;
            end else begin
                tvalid = '0;
            end
            #1;
            in_fire  = (tvalid == 4'b1111) && (bus_a.data_i_tready == 4'b1111);
            out_fire = bus_a.data_o_tvalid && out_ready;
            if (out_fire) begin
                total++;
                if (bus_a.data_o_tdata !== 16'(4*rcv + 6)) $display("FAIL bp_value beat %0d got %0d want %0d", rcv, bus_a.data_o_tdata, 4*rcv + 6);
                else pass_cnt++;
                rcv++;
            end
            if (bus_a.data_o_tvalid && !out_ready) begin
                total++;
                if (bus_a.data_i_tready !== 4'b0000) $display("FAIL bp_stall_tready got %b want 0000", bus_a.data_i_tready);
                else pass_cnt++;
            end
            if (in_fire) idx++;
            tick();
        end
        tvalid = '0; out_ready = 1'b1;
        total++;
        if (rcv !== 8) $display("FAIL bp_count got %0d want 8", rcv);
        else pass_cnt++;
        total++;
        if (idx !== 8) $display("FAIL bp_sent got %0d want 8", idx);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic got, oa, os, on_;
        logic [OW-1:0] da, ds, dn, exp_pos, exp_neg;
        logic exp_ovf;
`ifdef STREAM_ADDER_TREE_SATURATE_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000; exp_ovf = 1'b1;
`else
        exp_pos = 16'hFFFC; exp_neg = 16'h0000; exp_ovf = 1'b0;
`endif
        send_one({4{16'h7FFF}}, got, da, ds, dn, oa, os, on_);
        total++;
        if (got !== 1'b1) $display("FAIL ovf_pos_timeout got %b want 1", got);
        else pass_cnt++;
        total++;
        if (da !== exp_pos) $display("FAIL ovf_pos_data got %h want %h", da, exp_pos);
        else pass_cnt++;
        total++;
        if (oa !== exp_ovf) $display("FAIL ovf_pos_flag got %b want %b", oa, exp_ovf);
        else pass_cnt++;
        send_one({4{16'h8000}}, got, da, ds, dn, oa, os, on_);
        total++;
        if (got !== 1'b1) $display("FAIL ovf_neg_timeout got %b want 1", got);
        else pass_cnt++;
        total++;
        if (da !== exp_neg) $display("FAIL ovf_neg_data got %h want %h", da, exp_neg);
        else pass_cnt++;
        total++;
        if (oa !== exp_ovf) $display("FAIL ovf_neg_flag got %b want %b", oa, exp_ovf);
        else pass_cnt++;
    endtask

    task automatic test_sub_mask();
        logic got, oa, os, on_;
        logic [OW-1:0] da, ds, dn, exp_n;
        logic exp_novf;
`ifdef STREAM_ADDER_TREE_SATURATE_EN
        exp_n = 16'h7FFF; exp_novf = 1'b1;
`else
        exp_n = 16'h8000; exp_novf = 1'b0;
`endif
        send_one({16'd40, 16'd30, 16'd20, 16'd10}, got, da, ds, dn, oa, os, on_);
        total++;
        if (got !== 1'b1) $display("FAIL sub_timeout got %b want 1", got);
        else pass_cnt++;
        total++;
        if (ds !== 16'd60) $display("FAIL sub_mask_sum got %0d want 60", $signed(ds));
        else pass_cnt++;
        total++;
        if (os !== 1'b0) $display("FAIL sub_mask_ovf got %b want 0", os);
        else pass_cnt++;
        total++;
        if (da !== 16'd100) $display("FAIL add_ref_sum got %0d want 100", $signed(da));
        else pass_cnt++;
        send_one({16'd0, 16'd0, 16'd0, 16'h8000}, got, da, ds, dn, oa, os, on_);
        total++;
        if (dn !== exp_n) $display("FAIL neg_min_data got %h want %h", dn, exp_n);
        else pass_cnt++;
        total++;
        if (on_ !== exp_novf) $display("FAIL neg_min_ovf got %b want %b", on_, exp_novf);
        else pass_cnt++;
        total++;
        if (da !== 16'h8000) $display("FAIL min_plain_data got %h want 8000", da);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; tdata = '0; tvalid = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_join();
        test_backpressure();
        test_overflow();
        test_sub_mask();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
